lfsr_rng: RTL
=============

Name: lfsr_rng

Overview:
Parametrised Galois LFSR random-number generator with runtime seed load and request/response handshakes. Each accepted request produces one draw in the selected mode: raw word, 2-bit value, or bounded range 1..RANGE_MAX via rejection sampling. Zero-lock protection is built in. Feeds the EC population-init and mutation/crossover datapaths, which need INT8 genes, 0~3 selectors and 1~40 indices from one source.

Parameters:
WIDTH, 8, LFSR state and raw output width (>=4)
TAP_MASK, 8'hB8, Galois right-shift feedback mask; default realises x^8+x^6+x^5+x^4+1
DEFAULT_SEED, 8'h01, state after reset and substitute for any zero seed; must be nonzero
STEPS_PER_OUT, 1, LFSR steps per draw attempt (>=1), for decorrelation
RANGE_MAX, 40, upper bound of range mode; constraint 2^(RBITS-1) < RANGE_MAX <= 2^RBITS
RBITS, 6, low state bits used in range mode (RBITS <= WIDTH)
MAX_RETRY, 4, rejected attempts allowed before fallback

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
seed_valid  in  1  load seed this cycle
seed  in  WIDTH  seed value
req_valid  in  1  draw request
req_mode  in  2  0 raw, 1 low 2 bits, 2 range 1..RANGE_MAX, 3 reserved (treated as 0)
req_ready  out  1  request accepted when req_valid & req_ready
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result, zero-extended
busy  out  1  draw in progress or result pending

Behaviour:
- Reset (rst=1 at posedge): state=DEFAULT_SEED, FSM=IDLE, out_valid=0, out_data=0, busy=0, retry counter=0. req_ready=1 in IDLE only.
- Step function: lsb=state[0]; state_next = (state>>1) ^ (lsb ? TAP_MASK : 0).
- Seed load: accepted in any state. state <= (seed==0 ? DEFAULT_SEED : seed); FSM -> IDLE; any pending request or result is discarded (out_valid=0). Priority: rst > seed_valid > everything else.
- FSM IDLE: on req_valid, latch mode; step counter=STEPS_PER_OUT; retry=0; -> STEP.
- FSM STEP: advance state one step per cycle; decrement step counter; when it reaches 0, -> EVAL.
- FSM EVAL (one cycle, combinational on current state, no step):
  - mode 0/3: out_data=state.
  - mode 1: out_data=state[1:0].
  - mode 2: r=state[RBITS-1:0]. If r<RANGE_MAX, out_data=r+1. Else if retry<MAX_RETRY: retry++, reload step counter, -> STEP. Else out_data=(r-RANGE_MAX)+1 (always within 1..RANGE_MAX by the parameter constraint).
  - On result: out_valid=1, -> HOLD.
- FSM HOLD: out_data and state frozen; when out_ready=1, out_valid=0 next cycle and -> IDLE. A new request is not accepted in the same cycle as the handoff.
- Latency: request accept to out_valid = STEPS_PER_OUT+1 cycles with no rejections; each rejection adds STEPS_PER_OUT+1 cycles. Bounded at (MAX_RETRY+1)*(STEPS_PER_OUT+1).
- busy=1 in STEP, EVAL and HOLD.
- The state never holds 0. With a primitive TAP_MASK, the period is 2^WIDTH-1.

Test Plan:
- Reset, then seed 8'h01, then 5 mode-0 requests with out_ready=1 -> out_data 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3; each out_valid arrives 2 cycles after accept.
- Seed 8'h00 -> behaves as 8'h01; first mode-0 draw = 8'hB8. Run 255 draws -> the 255th returns 8'h01, with no repeat earlier.
- Seed 8'h17, mode 1 -> state steps to 8'hB3, out_data=2'b11.
- Seed 8'h17, mode 2 -> r=0x33=51 is rejected; state -> 0xE1, r=0x21=33 -> out_data=34, out_valid 4 cycles after accept. Run 1000 mode-2 draws -> every value in 1..40, with the fallback path exercised.
- Hold out_ready=0 for 10 cycles -> out_data stable, out_valid=1, req_ready=0. Assert seed_valid during HOLD -> out_valid drops next cycle, FSM returns to IDLE, new seed is loaded.
- Assert rst mid-STEP with STEPS_PER_OUT=3 -> next cycle state=DEFAULT_SEED, out_valid=0, busy=0, req_ready=1.

Source files
------------

// File: rtl/lfsr_rng.sv
// Galois LFSR random-number generator with seed load and request/response handshakes.
// Draws are raw words, 2-bit selectors, or 1..RANGE_MAX values obtained by rejection sampling.
module lfsr_rng #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TAP_MASK      = WIDTH'('hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED  = WIDTH'('h01),
  parameter int               STEPS_PER_OUT = 1,
  parameter int               RANGE_MAX     = 40,
  parameter int               RBITS         = 6,
  parameter int               MAX_RETRY     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  input  logic             req_valid,
  input  logic [1:0]       req_mode,
  output logic             req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int SCW = $clog2(STEPS_PER_OUT + 1);
  localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [SCW-1:0]   STEP_LOAD = SCW'(STEPS_PER_OUT);
  localparam logic [RCW-1:0]   RETRY_LIM = RCW'(MAX_RETRY);
  localparam logic [WIDTH:0]   RMAX_EXT  = (WIDTH+1)'(RANGE_MAX);
  localparam logic [WIDTH-1:0] RMAX_W    = WIDTH'(RANGE_MAX);

  typedef enum logic [1:0] {IDLE, STEP, EVAL, HOLD} state_t;

  state_t           fsm;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [SCW-1:0]   step_cnt;
  logic [RCW-1:0]   retry;
  logic [1:0]       mode;

  logic [WIDTH-1:0] r;
  logic             in_range;
  logic             reject;
  logic [WIDTH-1:0] result;

  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAP_MASK : '0);

  // Range mode works on the low RBITS only; the fallback fold stays in 1..RANGE_MAX
  // because RANGE_MAX exceeds half the RBITS space.
  assign r        = WIDTH'(lfsr[RBITS-1:0]);
  assign in_range = {1'b0, r} < RMAX_EXT;
  assign reject   = (mode == 2'd2) && !in_range && (retry < RETRY_LIM);

  always_comb begin
    result = lfsr;
    case (mode)
      2'd1:    result = WIDTH'(lfsr[1:0]);
      2'd2:    result = in_range ? (r + WIDTH'(1)) : (r - RMAX_W + WIDTH'(1));
      default: result = lfsr;
    endcase
  end

  assign req_ready = (fsm == IDLE);
  assign busy      = (fsm != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      lfsr      <= DEFAULT_SEED;
      step_cnt  <= '0;
      retry     <= '0;
      mode      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (seed_valid) begin
      // A zero seed would lock the register, so it maps onto the default seed.
      fsm       <= IDLE;
      lfsr      <= (seed == '0) ? DEFAULT_SEED : seed;
      step_cnt  <= '0;
      retry     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (req_valid) begin
          mode     <= req_mode;
          step_cnt <= STEP_LOAD;
          retry    <= '0;
          fsm      <= STEP;
        end
        STEP: begin
          lfsr     <= lfsr_next;
          step_cnt <= step_cnt - SCW'(1);
          if (step_cnt == SCW'(1)) fsm <= EVAL;
        end
        EVAL: if (reject) begin
          retry    <= retry + RCW'(1);
          step_cnt <= STEP_LOAD;
          fsm      <= STEP;
        end else begin
          out_data  <= result;
          out_valid <= 1'b1;
          fsm       <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
